// File: rtl/float_copro_ctrl.sv
// Sequencing controller between the LM32 user-defined-instruction port and a
// combinational float datapath: holds operands stable, waits, captures result.
module float_copro_ctrl #(
    parameter int WAIT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [10:0]      opcode_i,
    input  logic [31:0]      op0_i,
    input  logic [31:0]      op1_i,
    output logic [31:0]      result_o,
    output logic             done_o,
    output logic             busy_o,
    output logic [10:0]      dp_opcode_o,
    output logic [31:0]      dp_op0_o,
    output logic [31:0]      dp_op1_o,
    input  logic [31:0]      dp_result_i,
    input  logic             clr_flags_i,
    output logic             illegal_o,
    output logic             overrun_o,
    output logic [CNT_W-1:0] op_count_o
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       accept;
    logic       legal;

    assign accept = (state == IDLE) && start_i;
    assign legal  = (opcode_i <= 11'd3);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = legal ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (wait_cnt == 8'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Both status outputs decode the state register only, so neither has an input path.
    always_comb begin
        done_o = (state == DONE);
        busy_o = (state != IDLE);
    end

    // Datapath inputs move only on accept, which keeps them frozen for all of EXEC.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dp_opcode_o <= '0;
            dp_op0_o    <= '0;
            dp_op1_o    <= '0;
            result_o    <= '0;
            wait_cnt    <= '0;
            op_count_o  <= '0;
        end else begin
            if (accept) begin
                dp_op0_o <= op0_i;
                dp_op1_o <= op1_i;
                if (legal) begin
                    dp_opcode_o <= opcode_i;
                    wait_cnt    <= 8'(WAIT_CYCLES - 1);
                end else begin
                    result_o <= '0;
                end
            end else if (state == EXEC) begin
                if (wait_cnt != 8'd0) begin
                    wait_cnt <= wait_cnt - 8'd1;
                end else begin
                    result_o   <= dp_result_i;
                    op_count_o <= op_count_o + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Sticky flags: a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            illegal_o <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            illegal_o <= (accept && !legal) || (illegal_o && !clr_flags_i);
            overrun_o <= (start_i && (state != IDLE)) || (overrun_o && !clr_flags_i);
        end
    end

endmodule

// File: tb/tb_float_copro_ctrl.sv
// Directed testbench for float_copro_ctrl; a small lookup model stands in
// for the float datapath and expected values are hand-computed constants.
module tb_float_copro_ctrl;

    localparam logic [31:0] F1 = 32'h3F800000;
    localparam logic [31:0] F2 = 32'h40000000;
    localparam logic [31:0] F3 = 32'h40400000;
    localparam logic [31:0] F6 = 32'h40C00000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [10:0] opcode = '0;
    logic [31:0] op0 = '0;
    logic [31:0] op1 = '0;
    logic        clr = 1'b0;
    logic [31:0] result, dp_op0, dp_op1, dp_result;
    logic [10:0] dp_opcode;
    logic        done, busy, illegal, overrun;
    logic [15:0] op_count;

    logic        start2 = 1'b0;
    logic [31:0] result2, dp_op0_2, dp_op1_2, dp_result2;
    logic [10:0] dp_opcode2;
    logic        done2, busy2, illegal2, overrun2;
    logic [1:0]  op_count2;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] fp_model(input logic [10:0] opc, input logic [31:0] a, input logic [31:0] b);
        if (opc == 11'd0 && a == F1 && b == F2) return F3;
        if (opc == 11'd1 && a == F3 && b == F1) return F2;
        if (opc == 11'd2 && a == F2 && b == F3) return F6;
        if (opc == 11'd3 && a == F6 && b == F2) return F3;
        return 32'hDEADBEEF;
    endfunction

    always_comb dp_result  = fp_model(dp_opcode, dp_op0, dp_op1);
    always_comb dp_result2 = fp_model(dp_opcode2, dp_op0_2, dp_op1_2);

    float_copro_ctrl #(.WAIT_CYCLES(4), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .opcode_i(opcode),
        .op0_i(op0), .op1_i(op1), .result_o(result), .done_o(done),
        .busy_o(busy), .dp_opcode_o(dp_opcode), .dp_op0_o(dp_op0),
        .dp_op1_o(dp_op1), .dp_result_i(dp_result), .clr_flags_i(clr),
        .illegal_o(illegal), .overrun_o(overrun), .op_count_o(op_count)
    );

    float_copro_ctrl #(.WAIT_CYCLES(1), .CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .opcode_i(opcode),
        .op0_i(op0), .op1_i(op1), .result_o(result2), .done_o(done2),
        .busy_o(busy2), .dp_opcode_o(dp_opcode2), .dp_op0_o(dp_op0_2),
        .dp_op1_o(dp_op1_2), .dp_result_i(dp_result2), .clr_flags_i(1'b0),
        .illegal_o(illegal2), .overrun_o(overrun2), .op_count_o(op_count2)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; start2 = 1'b0; clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge (cycle 0); returns at the cycle-1 sample point.
    task automatic issue(input logic [10:0] opc, input logic [31:0] a, input logic [31:0] b);
        opcode = opc; op0 = a; op1 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({done, busy, illegal, overrun} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {done, busy, illegal, overrun});
        end
        tests_run++;
        if ({result, dp_op0, dp_op1, dp_opcode, op_count} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_regs: result %h dp_op0 %h dp_op1 %h dp_opcode %h count %h expected all 0",
                     result, dp_op0, dp_op1, dp_opcode, op_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        logic exp_done, exp_busy;
        do_reset();
        @(negedge clk);
        issue(11'd0, F1, F2);
        for (int c = 1; c <= 6; c++) begin
            exp_done = (c == 5);
            exp_busy = (c <= 5);
            tests_run++;
            if (done !== exp_done) begin
                tests_failed++;
                $display("[TB] FAIL add_done_c%0d: got %b expected %b", c, done, exp_done);
            end
            tests_run++;
            if (busy !== exp_busy) begin
                tests_failed++;
                $display("[TB] FAIL add_busy_c%0d: got %b expected %b", c, busy, exp_busy);
            end
            if (c == 3) begin
                tests_run++;
                if (dp_op0 !== F1 || dp_op1 !== F2) begin
                    tests_failed++;
                    $display("[TB] FAIL add_dp_hold: got %h %h expected %h %h", dp_op0, dp_op1, F1, F2);
                end
            end
            if (c < 6) @(negedge clk);
        end
        tests_run++;
        if (result !== F3) begin
            tests_failed++;
            $display("[TB] FAIL add_result: got %h expected %h", result, F3);
        end
        tests_run++;
        if (op_count !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL add_count: got %0d expected 1", op_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        issue(11'd1, F3, F1);
        repeat (4) @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || result !== F2) begin
            tests_failed++;
            $display("[TB] FAIL b2b_sub: done %b result %h expected 1 %h", done, result, F2);
        end
        @(negedge clk);
        issue(11'd2, F2, F3);
        repeat (4) @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || result !== F6) begin
            tests_failed++;
            $display("[TB] FAIL b2b_mul: done %b result %h expected 1 %h", done, result, F6);
        end
        tests_run++;
        if (op_count !== 16'd2 || overrun !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_status: count %0d overrun %b expected 2 0", op_count, overrun);
        end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        issue(11'd7, F1, F2);
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ill_done: done %b busy %b expected 1 1", done, busy);
        end
        tests_run++;
        if (result !== 32'h0 || illegal !== 1'b1 || op_count !== 16'd2) begin
            tests_failed++;
            $display("[TB] FAIL ill_state: result %h illegal %b count %0d expected 0 1 2", result, illegal, op_count);
        end
        tests_run++;
        if (dp_op0 !== F1 || dp_op1 !== F2) begin
            tests_failed++;
            $display("[TB] FAIL ill_operands: got %h %h expected %h %h", dp_op0, dp_op1, F1, F2);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ill_idle: done %b busy %b expected 0 0", done, busy);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        tests_run++;
        if (illegal !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ill_clear: got %b expected 0", illegal);
        end
    endtask

    task automatic test_overrun();
        int dones;
        dones = 0;
        issue(11'd3, F6, F2);
        for (int c = 1; c <= 8; c++) begin
            if (done === 1'b1) dones++;
            if (c == 2) begin
                opcode = 11'd0; op0 = F1; op1 = F1; start = 1'b1;
            end
            if (c == 3) start = 1'b0;
            @(negedge clk);
        end
        tests_run++;
        if (dones != 1) begin
            tests_failed++;
            $display("[TB] FAIL ovr_done_count: got %0d expected 1", dones);
        end
        tests_run++;
        if (result !== F3 || dp_opcode !== 11'd3) begin
            tests_failed++;
            $display("[TB] FAIL ovr_result: result %h opcode %0d expected %h 3", result, dp_opcode, F3);
        end
        tests_run++;
        if (overrun !== 1'b1 || op_count !== 16'd3) begin
            tests_failed++;
            $display("[TB] FAIL ovr_flag: overrun %b count %0d expected 1 3", overrun, op_count);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ovr_clear: got %b expected 0", overrun);
        end
        issue(11'd0, F1, F2);
        @(negedge clk);
        start = 1'b1; clr = 1'b1;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        tests_run++;
        if (overrun !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ovr_set_wins: got %b expected 1", overrun);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (result !== F3 || op_count !== 16'd4 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ovr_after: result %h count %0d busy %b expected %h 4 0", result, op_count, busy, F3);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        issue(11'd0, F1, F2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({done, busy, illegal, overrun} !== 4'b0000 || {result, dp_op0, dp_op1, dp_opcode, op_count} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset: done %b busy %b result %h dp_op0 %h count %0d expected all 0",
                     done, busy, result, dp_op0, op_count);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        tests_run++;
        if (dones != 0 || op_count !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL mid_no_done: dones %0d count %0d expected 0 0", dones, op_count);
        end
        issue(11'd1, F3, F1);
        repeat (4) @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || result !== F2 || op_count !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL mid_recover: done %b result %h count %0d expected 1 %h 1", done, result, op_count, F2);
        end
        @(negedge clk);
    endtask

    task automatic test_counter_wrap();
        logic [1:0] exp_cnt;
        do_reset();
        @(negedge clk);
        opcode = 11'd0; op0 = F1; op1 = F2;
        for (int k = 0; k < 5; k++) begin
            exp_cnt = 2'(k + 1);
            start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            tests_run++;
            if (done2 !== 1'b0 || busy2 !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL wrap_c1_%0d: done %b busy %b expected 0 1", k, done2, busy2);
            end
            @(negedge clk);
            tests_run++;
            if (done2 !== 1'b1 || op_count2 !== exp_cnt || result2 !== F3) begin
                tests_failed++;
                $display("[TB] FAIL wrap_%0d: done %b count %0d result %h expected 1 %0d %h",
                         k, done2, op_count2, result2, exp_cnt, F3);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_illegal();
        test_overrun();
        test_reset_mid();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/float_copro_ctrl.md
Name: float_copro_ctrl

Overview:
Sequencing controller placed between the LM32 user-defined-instruction interface and the combinational float coprocessor datapath (add/sub/mul/div, opcodes 0..3). Registers the opcode and operands on a start pulse and holds them stable on the datapath inputs for a programmable number of settling cycles. It then captures the datapath result and returns it with a one-cycle done pulse. It also reports illegal opcodes, starts issued while busy, and a completed-operation count.

Parameters:
WAIT_CYCLES, 4, clock cycles allowed for the datapath to settle; legal range 1..255
CNT_W, 16, width of the completed-operation counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
start_i  in  1  request pulse; sampled only in IDLE
opcode_i  in  11  operation code; 0 add, 1 sub, 2 mul, 3 div
op0_i  in  32  operand 0, IEEE-754 single
op1_i  in  32  operand 1, IEEE-754 single
result_o  out  32  registered result; held until the next capture
done_o  out  1  one-cycle completion pulse
busy_o  out  1  high whenever state is not IDLE
dp_opcode_o  out  11  registered opcode driven to the datapath
dp_op0_o  out  32  registered operand 0 driven to the datapath
dp_op1_o  out  32  registered operand 1 driven to the datapath
dp_result_i  in  32  combinational result from the datapath
clr_flags_i  in  1  synchronous clear of the sticky flags
illegal_o  out  1  sticky: an opcode greater than 3 was accepted
overrun_o  out  1  sticky: start_i was seen while busy
op_count_o  out  CNT_W  count of legal operations completed; wraps modulo 2^CNT_W

Behaviour:
- Reset (asynchronous, rst_i high): state IDLE. result_o, dp_*, op_count_o and the internal wait counter go to 0. done_o, busy_o, illegal_o and overrun_o go to 0. Reset asserted mid-operation aborts the operation: no done pulse and no count increment.
- FSM states are IDLE, EXEC and DONE.
- IDLE with start_i=1 and opcode_i<=3:
  - Latch opcode_i, op0_i and op1_i into dp_*.
  - Load the wait counter with WAIT_CYCLES-1.
  - Go to EXEC.
- IDLE with start_i=1 and opcode_i>3:
  - Latch the operands; set result_o=0 and illegal_o=1.
  - Go directly to DONE; op_count_o is unchanged.
- EXEC:
  - While the counter is nonzero, decrement it.
  - When the counter is 0, capture dp_result_i into result_o, increment op_count_o (wrapping) and go to DONE.
- DONE: done_o=1 for this cycle only; go to IDLE unconditionally.
- Latency:
  - Legal opcode: start_i high in cycle 0 gives done_o high in cycle WAIT_CYCLES+1.
  - Illegal opcode: done_o high in cycle 1.
  - Minimum issue interval is WAIT_CYCLES+2 cycles.
- dp_* outputs change only on accept in IDLE, so the datapath inputs are stable throughout EXEC.
- start_i in EXEC or DONE: the request is ignored and overrun_o is set. The operation in flight is unaffected.
- Sticky flags:
  - clr_flags_i=1 clears illegal_o and overrun_o on the next edge.
  - If a set condition occurs in the same cycle as clr_flags_i, the set wins.
- result_o and done_o are registered outputs, with no combinational path from any input.

Test Plan:
- Reset then add: op0=0x3F800000 (1.0), op1=0x40000000 (2.0), opcode 0, WAIT_CYCLES=4, start in cycle 0 -> busy_o high in cycles 1-5; done_o high in cycle 5 only; result_o=0x40400000 (3.0); op_count_o=1.
- Back-to-back issue: sub 3.0-1.0, then mul 2.0*3.0 issued the cycle after done -> results 0x40000000 then 0x40C00000 (6.0); op_count_o=2; overrun_o stays 0.
- Illegal opcode 7 -> done_o high in cycle 1; result_o=0; illegal_o=1; op_count_o unchanged. Then assert clr_flags_i -> illegal_o=0 on the next cycle.
- Start while busy: issue div 6.0/2.0, re-pulse start with opcode 0 in cycle 2 -> result_o=0x40400000; exactly one done pulse; overrun_o=1. Assert clr_flags_i together with a new overrun -> overrun_o remains 1.
- Reset mid-EXEC: assert rst_i in cycle 2 of an operation -> all outputs 0 immediately; no done pulse; the next operation completes normally.
- Counter wrap with CNT_W=2: five legal operations -> op_count_o sequence 1, 2, 3, 0, 1.
